// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store encodings, LSU state encoding and small decode helpers.
// Purely declarative: no logic, no latency, no flow control.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    REQ1 = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } lsu_state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      f3_legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte-enable/data shifting for stores, extraction and extension for loads.
// Purely combinational (zero latency); no flow control.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic        split,
  output logic [7:0]  be_mask,
  output logic [63:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [3:0]  size_mask;
  logic [31:0] raw;

  assign split = ({1'b0, offset} + size_bytes(funct3[1:0])) > 3'd4;

  always_comb begin
    case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    be_mask     = {4'b0000, size_mask} << offset;
    wdata_lanes = {32'h0, wdata} << {offset, 3'b000};
    raw         = 32'({hi, lo} >> {offset, 3'b000});
    // funct3[2] selects zero extension; otherwise replicate the top bit of the field
    case (funct3[1:0])
      2'b00:   load_data = funct3[2] ? {24'h0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      2'b01:   load_data = funct3[2] ? {16'h0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request per start, 1-2 word-aligned memory transactions, done pulse.
// Latency 2 cycles (3 if split) with immediate ack; mem_req held until mem_ack, starts ignored while busy.
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       lo_q;
  logic [31:0]       rdata_q;

  logic [2:0]        a_funct3;
  logic [1:0]        a_offset;
  logic [31:0]       a_lo, a_hi;
  logic              split;
  logic [7:0]        be_mask;
  logic [63:0]       wdata_lanes;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] word_addr;

  // In IDLE the aligner decodes the incoming request so the split check can steer IDLE->ERR.
  assign a_funct3 = (state_q == IDLE) ? funct3    : req_q.funct3;
  assign a_offset = (state_q == IDLE) ? addr[1:0] : addr_q[1:0];
  assign a_lo     = (state_q == REQ1) ? lo_q      : mem_rdata;
  assign a_hi     = (state_q == REQ1) ? mem_rdata : 32'h0;

  lsu_align u_align (
    .funct3      (a_funct3),
    .offset      (a_offset),
    .wdata       (req_q.wdata),
    .lo          (a_lo),
    .hi          (a_hi),
    .split       (split),
    .be_mask     (be_mask),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data)
  );

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'h0;
    mem_wdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!f3_legal(is_store, funct3) || (split && !ALLOW_MISALIGNED))
            state_d = ERR;
          else
            state_d = REQ0;
        end
      end
      REQ0: begin
        mem_req   = 1'b1;
        mem_we    = req_q.is_store;
        mem_addr  = word_addr;
        mem_be    = req_q.is_store ? be_mask[3:0] : 4'hf;
        mem_wdata = req_q.is_store ? wdata_lanes[31:0] : 32'h0;
        if (mem_ack) state_d = split ? REQ1 : DONE;
      end
      REQ1: begin
        mem_req   = 1'b1;
        mem_we    = req_q.is_store;
        mem_addr  = word_addr + ADDR_W'(4);
        mem_be    = req_q.is_store ? be_mask[7:4] : 4'hf;
        mem_wdata = req_q.is_store ? wdata_lanes[63:32] : 32'h0;
        if (mem_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        req_q.is_store <= is_store;
        req_q.funct3   <= funct3;
        req_q.wdata    <= wdata;
        addr_q         <= addr;
      end
      if (state_q == REQ0 && mem_ack)
        lo_q <= mem_rdata;
      // Load result lands on the last ack so it is visible during DONE.
      if (!req_q.is_store && mem_ack &&
          ((state_q == REQ0 && !split) || state_q == REQ1))
        rdata_q <= load_data;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE) || (state_q == ERR);
  assign err   = (state_q == ERR);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: table of directed load/store vectors against a word memory model, plus hand sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        s_start;
  logic        s_busy, s_done, s_err;
  logic [31:0] s_rdata;
  logic        s_mem_req, s_mem_we, s_mem_ack;
  logic [31:0] s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [3:0]  s_mem_be;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [31:0] mem [64];

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  lsu_ctrl #(.ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) u_dut_strict (
    .clk(clk), .reset(reset), .start(s_start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(s_busy), .done(s_done), .err(s_err), .rdata(s_rdata),
    .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_be(s_mem_be),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .mem_ack(s_mem_ack)
  );

  assign s_mem_rdata = 32'h12345678;
  assign s_mem_ack   = s_mem_req;

  // Memory model: 64 words aliased on addr[7:2], ack after ack_delay wait cycles.
  assign mem_rdata = mem[mem_addr[7:2]];
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (mem_req && mem_ack && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
  end

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e;
    int          cyc;
    int          ntx;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  int          ntx;
  logic [31:0] tx_a  [2];
  logic [3:0]  tx_be [2];
  logic [31:0] tx_wd [2];
  logic        tx_we [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int cyc, output logic e,
                        output logic [31:0] rd);
    @(negedge clk);
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    ntx = 0;
    while (!done && cyc < 64) begin
      if (mem_req && mem_ack) begin
        if (ntx < 2) begin
          tx_a[ntx] = mem_addr; tx_be[ntx] = mem_be;
          tx_wd[ntx] = mem_wdata; tx_we[ntx] = mem_we;
        end
        ntx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 64) begin
      errors++;
      $display("FAIL op timeout: got no done expected done within 64 cycles");
    end
    e  = err;
    rd = rdata;
  endtask

  initial begin
    int          cyc, req_cyc, dcount, done_at;
    logic        e, stable, busy_mid;
    logic [31:0] rd;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'habcde4ef;
    mem[5]  = 32'h11223344;
    mem[63] = 32'h55000000;
    mem[0]  = 32'h00000066;

    //            st   f3      addr          wdata         rdata         e   cyc ntx a0            be0   wd0           a1            be1   wd1
    vt[0]  = '{1'b0, 3'b010, 32'h00000010, 32'h0,        32'habcde4ef, 1'b0, 2, 1, 32'h10,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[1]  = '{1'b0, 3'b001, 32'h00000010, 32'h0,        32'hffffe4ef, 1'b0, 2, 1, 32'h10,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[2]  = '{1'b0, 3'b101, 32'h00000010, 32'h0,        32'h0000e4ef, 1'b0, 2, 1, 32'h10,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[3]  = '{1'b0, 3'b000, 32'h00000011, 32'h0,        32'hffffffe4, 1'b0, 2, 1, 32'h10,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[4]  = '{1'b0, 3'b100, 32'h00000010, 32'h0,        32'h000000ef, 1'b0, 2, 1, 32'h10,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[5]  = '{1'b0, 3'b010, 32'h00000012, 32'h0,        32'h3344abcd, 1'b0, 3, 2, 32'h10,       4'hf, 32'h0,        32'h14,       4'hf, 32'h0};
    vt[6]  = '{1'b1, 3'b001, 32'h00000013, 32'h0000beef, 32'h0,        1'b0, 3, 2, 32'h10,       4'h8, 32'hef000000, 32'h14,       4'h1, 32'h000000be};
    vt[7]  = '{1'b0, 3'b010, 32'h00000010, 32'h0,        32'hefcde4ef, 1'b0, 2, 1, 32'h10,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[8]  = '{1'b0, 3'b010, 32'h00000014, 32'h0,        32'h112233be, 1'b0, 2, 1, 32'h14,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[9]  = '{1'b0, 3'b001, 32'h00000016, 32'h0,        32'h00001122, 1'b0, 2, 1, 32'h14,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[10] = '{1'b0, 3'b100, 32'h00000017, 32'h0,        32'h00000011, 1'b0, 2, 1, 32'h14,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[11] = '{1'b1, 3'b000, 32'h00000015, 32'hffffffaa, 32'h0,        1'b0, 2, 1, 32'h14,       4'h2, 32'hffffaa00, 32'h0,        4'h0, 32'h0};
    vt[12] = '{1'b0, 3'b010, 32'h00000014, 32'h0,        32'h1122aabe, 1'b0, 2, 1, 32'h14,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[13] = '{1'b0, 3'b001, 32'hffffffff, 32'h0,        32'h00006655, 1'b0, 3, 2, 32'hfffffffc, 4'hf, 32'h0,        32'h00000000, 4'hf, 32'h0};
    vt[14] = '{1'b1, 3'b011, 32'h00000010, 32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[15] = '{1'b0, 3'b110, 32'h00000010, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[16] = '{1'b0, 3'b000, 32'h00000013, 32'h0,        32'hffffffef, 1'b0, 2, 1, 32'h10,       4'hf, 32'h0,        32'h0,        4'h0, 32'h0};
    vt[17] = '{1'b1, 3'b010, 32'h00000011, 32'ha1b2c3d4, 32'h0,        1'b0, 3, 2, 32'h10,       4'he, 32'hb2c3d400, 32'h14,       4'h1, 32'h000000a1};
    vt[18] = '{1'b0, 3'b010, 32'h00000011, 32'h0,        32'ha1b2c3d4, 1'b0, 3, 2, 32'h10,       4'hf, 32'h0,        32'h14,       4'hf, 32'h0};

    reset = 1'b0; start = 1'b0; s_start = 1'b0;
    is_store = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    #2;
    chk("reset busy/done/err", {busy, done, err}, 3'b000);
    chk("reset mem_req/we/be", {mem_req, mem_we, mem_be}, 6'h00);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_addr/wdata", {mem_addr, mem_wdata}, 64'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, cyc, e, rd);
      chk($sformatf("v%0d done cycle", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d err", i), e, vt[i].e);
      chk($sformatf("v%0d txn count", i), ntx, vt[i].ntx);
      if (!vt[i].st && !vt[i].e) chk($sformatf("v%0d rdata", i), rd, vt[i].rd);
      if (vt[i].ntx >= 1) begin
        chk($sformatf("v%0d txn0 addr/be/we", i), {tx_a[0], tx_be[0], tx_we[0]},
            {vt[i].a0, vt[i].be0, vt[i].st});
        if (vt[i].st) chk($sformatf("v%0d txn0 wdata", i), tx_wd[0], vt[i].wd0);
      end
      if (vt[i].ntx == 2) begin
        chk($sformatf("v%0d txn1 addr/be/we", i), {tx_a[1], tx_be[1], tx_we[1]},
            {vt[i].a1, vt[i].be1, vt[i].st});
        if (vt[i].st) chk($sformatf("v%0d txn1 wdata", i), tx_wd[1], vt[i].wd1);
      end
    end

    // Ack delayed 3 cycles, with a stray start while busy.
    ack_delay = 3;
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    req_cyc = 0; dcount = 0; done_at = 0; stable = 1'b1; busy_mid = 1'b0; rd = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_req) begin
        req_cyc++;
        if (mem_addr !== 32'h10 || mem_be !== 4'hf || mem_we !== 1'b0) stable = 1'b0;
      end
      if (done) begin dcount++; done_at = c; rd = rdata; end
      if (c == 3) busy_mid = busy;
      start = (c == 2);
      if (c == 2) addr = 32'h14;
      @(negedge clk);
    end
    start = 1'b0;
    ack_delay = 0;
    chk("delay req cycles", req_cyc, 4);
    chk("delay req stable", stable, 1'b1);
    chk("delay busy mid", busy_mid, 1'b1);
    chk("delay done count", dcount, 1);
    chk("delay done cycle", done_at, 5);
    chk("delay rdata", rd, 32'hb2c3d4ef);

    // Misaligned access on the strict instance, then an aligned one.
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h12; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    req_cyc = 0; done_at = 0; e = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (s_mem_req) req_cyc++;
      if (s_done && done_at == 0) begin done_at = c; e = s_err; end
      @(negedge clk);
    end
    chk("strict misaligned done cycle", done_at, 1);
    chk("strict misaligned err", e, 1'b1);
    chk("strict misaligned no mem_req", req_cyc, 0);
    addr = 32'h10; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    req_cyc = 0; done_at = 0; e = 1'b1; rd = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      if (s_mem_req) req_cyc++;
      if (s_done && done_at == 0) begin done_at = c; e = s_err; rd = s_rdata; end
      @(negedge clk);
    end
    chk("strict aligned done cycle", done_at, 2);
    chk("strict aligned err", e, 1'b0);
    chk("strict aligned rdata", rd, 32'h12345678);
    chk("strict aligned req cycles", req_cyc, 1);

    // Reset asserted while the second half of a split load is pending.
    ack_delay = 3;
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset REQ1 req/addr", {mem_req, mem_addr}, {1'b1, 32'h14});
    reset = 1'b0;
    #1;
    chk("reset mid-txn mem_req/busy/done", {mem_req, busy, done}, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    run_op(1'b0, 3'b010, 32'h10, 32'h0, cyc, e, rd);
    chk("post-reset LW cycle", cyc, 2);
    chk("post-reset LW err", e, 1'b0);
    chk("post-reset LW rdata", rd, 32'hb2c3d4ef);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
